mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers. It is the responder for the ALU's multiply/divide requests: the execute stage issues MULT/MULTU/DIV/DIVU with two 32-bit operands, and the unit iterates for a fixed number of cycles. It returns the 64-bit product, or the remainder and quotient, in HI/LO. It also services MTHI/MTLO writes, and its HI/LO outputs feed MFHI/MFLO.

## Interface
Parameters:
- ITER, 32, iteration cycles per operation; must equal operand width.

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  `MDU_MULT`=00, `MDU_MULTU`=01, `MDU_DIV`=10, `MDU_DIVU`=11
- Read_data_1  in  32  operand A (multiplicand / dividend)
- Read_data_2  in  32  operand B (multiplier / divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wr_data  in  32  MTHI/MTLO data
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; HI/LO hold the new result
- div_zero  out  1  sticky until next start; last divide had B=0
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States:
  - IDLE: start=1 latches op, |A|, |B| and the result sign flags; counter←0; next state CALC.
  - CALC: one shift-add step (multiply) or one restoring shift-subtract step (divide) per cycle; counter increments; after ITER cycles, next state FIX.
  - FIX: applies signs, writes HI/LO, next state DONE.
  - DONE: done=1; next state IDLE.
- Multiply:
  - Unsigned 64-bit product of the magnitudes.
  - MULT negates the product when sign(A)≠sign(B).
  - {hi,lo}=product.
- Divide:
  - Unsigned restoring division of the magnitudes.
  - DIV: quotient negated when the signs differ; remainder takes the sign of A (truncation toward zero).
  - lo=quotient, hi=remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero:
  - Full latency still applies.
  - Result: lo=0xFFFFFFFF, hi=A (raw operand); div_zero=1.
  - Any start clears div_zero.
- Priority and conflicts:
  - start is ignored while busy.
  - hi_we/lo_we are honoured only in IDLE, and only when start=0. A simultaneous start drops the write.
  - Writes during busy are dropped.
- Operands are captured at start; later changes on Read_data_* have no effect.
- Reset mid-operation: immediate return to IDLE; all outputs go to their reset values; the partial result is discarded.

## Timing
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0, state=IDLE, counter=0.
- Start is accepted at edge E0. CALC occupies edges E1..E32, FIX is E33 (hi/lo updated at this edge), and done=1 during the cycle after E33.
- busy is high from after E0 through the done cycle: 34 cycles. The next start is accepted in the cycle after done.
- A back-to-back start on the first IDLE cycle is legal: the issue-to-issue interval is 35 cycles.
- MTHI/MTLO take effect at the same edge they are sampled; hi/lo are visible on the next cycle.
- hi/lo change only at FIX, at an honoured write, or at reset.

## Structure
- `definitions.v` gains:
  - `MDU_MULT`/`MDU_MULTU`/`MDU_DIV`/`MDU_DIVU` op codes
  - `MDU_IDLE`/`MDU_CALC`/`MDU_FIX`/`MDU_DONE` state encodings (2 bits)
  - `MDU_ITER`
- One sub-module, `mdu_sign_fix` (combinational): absolute-value extraction at start, and final negation of the product, quotient or remainder at FIX.
- The FSM, counter, 64-bit working register and HI/LO live in mul_div_unit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles done pulses: hi=0xFFFFFFFE, lo=0x00000001; busy was high for exactly 34 cycles.
- MULT 0xFFFFFFFD(-3) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7 / 2 → lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5, div_zero=1; a following MULTU 2×3 clears div_zero and gives hi=0, lo=6.
- Second start and hi_we=1 with wr_data=0x1234 asserted mid-CALC → both ignored; the result matches the first op. After done: lo_we with 0xABCD gives lo=0xABCD on the next cycle; start and hi_we in the same IDLE cycle leave hi unchanged until FIX.
- rst_n pulsed low at cycle 10 of CALC → busy=0, hi=lo=0 immediately; a new MULTU 3×4 then completes normally with lo=12.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM encodings and iteration count for the multiply/divide unit.
package mul_div_unit_pkg;

  localparam int MDU_ITER = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [1:0] MDU_IDLE = 2'b00;
  localparam logic [1:0] MDU_CALC = 2'b01;
  localparam logic [1:0] MDU_FIX  = 2'b10;
  localparam logic [1:0] MDU_DONE = 2'b11;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling for the MDU: operand magnitudes at issue, result negation at fix-up.
module mdu_sign_fix (
  input  logic        sgn,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] abs_a,
  output logic [31:0] abs_b,
  output logic        neg_q,
  output logic        neg_r,
  input  logic        fix_div,
  input  logic        fix_neg_q,
  input  logic        fix_neg_r,
  input  logic [63:0] work,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod;

  always_comb begin
    abs_a = (sgn && a[31]) ? -a : a;
    abs_b = (sgn && b[31]) ? -b : b;
    // neg_q doubles as the product sign for multiplies
    neg_q = sgn & (a[31] ^ b[31]);
    neg_r = sgn & a[31];
  end

  always_comb begin
    prod = fix_neg_q ? -work : work;
    if (fix_div) begin
      res_lo = fix_neg_q ? -work[31:0]  : work[31:0];
      res_hi = fix_neg_r ? -work[63:32] : work[63:32];
    end else begin
      res_lo = prod[31:0];
      res_hi = prod[63:32];
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO: one shift-add or restoring
// shift-subtract step per cycle, then a sign fix-up cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(ITER);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       op_reg;
  logic [63:0]      work_reg;
  logic [31:0]      opnd_reg;
  logic [31:0]      a_raw_reg;
  logic             b_zero_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic             div_zero_reg;

  logic [31:0] abs_a, abs_b, res_hi, res_lo;
  logic        neg_q, neg_r;
  logic [32:0] sum, cand, diff;
  logic [63:0] step;

  mdu_sign_fix u_sign_fix (
    .sgn       (op_is_signed(op)),
    .a         (Read_data_1),
    .b         (Read_data_2),
    .abs_a     (abs_a),
    .abs_b     (abs_b),
    .neg_q     (neg_q),
    .neg_r     (neg_r),
    .fix_div   (op_is_div(op_reg)),
    .fix_neg_q (neg_q_reg),
    .fix_neg_r (neg_r_reg),
    .work      (work_reg),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  // Multiply: work = {partial product, remaining multiplier bits}.
  // Divide:   work = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    sum  = {1'b0, work_reg[63:32]} + (work_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    cand = {work_reg[63:32], work_reg[31]};
    diff = cand - {1'b0, opnd_reg};
    if (op_is_div(op_reg)) begin
      step = diff[32] ? {cand[31:0], work_reg[30:0], 1'b0}
                      : {diff[31:0], work_reg[30:0], 1'b1};
    end else begin
      step = {sum, work_reg[31:1]};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= MDU_IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      work_reg     <= '0;
      opnd_reg     <= '0;
      a_raw_reg    <= '0;
      b_zero_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        MDU_IDLE: begin
          if (start) begin
            op_reg       <= op;
            work_reg     <= {32'd0, op_is_div(op) ? abs_a : abs_b};
            opnd_reg     <= op_is_div(op) ? abs_b : abs_a;
            a_raw_reg    <= Read_data_1;
            b_zero_reg   <= (Read_data_2 == 32'd0);
            neg_q_reg    <= neg_q;
            neg_r_reg    <= neg_r;
            cnt_reg      <= '0;
            div_zero_reg <= 1'b0;
            state_reg    <= MDU_CALC;
          end else begin
            if (hi_we) hi_reg <= wr_data;
            if (lo_we) lo_reg <= wr_data;
          end
        end
        MDU_CALC: begin
          work_reg <= step;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(ITER - 1)) state_reg <= MDU_FIX;
        end
        MDU_FIX: begin
          if (op_is_div(op_reg) && b_zero_reg) begin
            hi_reg       <= a_raw_reg;
            lo_reg       <= 32'hFFFF_FFFF;
            div_zero_reg <= 1'b1;
          end else begin
            hi_reg <= res_hi;
            lo_reg <= res_lo;
          end
          state_reg <= MDU_DONE;
        end
        default: state_reg <= MDU_IDLE;
      endcase
    end
  end

  assign busy     = (state_reg != MDU_IDLE);
  assign done     = (state_reg == MDU_DONE);
  assign div_zero = div_zero_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected {div_zero,hi,lo} queued at issue, compared at done.
module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] Read_data_1 = '0;
  logic [31:0] Read_data_2 = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int passed = 0;
  logic [64:0] sb[$];

  mul_div_unit dut (
    .clock(clock), .rst_n(rst_n), .start(start), .op(op),
    .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {div_zero, hi, lo}
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sbv;
    int q, r;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        p = 64'(sa * sbv);
        return {1'b0, p};
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b11) return {1'b0, a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {1'b0, 32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; Read_data_1 = a; Read_data_2 = b; start = 1'b1;
    sb.push_back(model(o, a, b));
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts busy cycles and done pulses; returns at the first idle cycle.
  task automatic run_wait(output int busy_n, output int done_n, output logic [64:0] res);
    busy_n = 0; done_n = 0; res = '0;
    while (busy && busy_n < 100) begin
      if (done) begin
        done_n++;
        res = {div_zero, hi, lo};
      end
      busy_n++;
      @(negedge clock);
    end
    $display("txn op=%0d a=%h b=%h -> dz=%0d hi=%h lo=%h busy=%0d done=%0d",
             op, Read_data_1, Read_data_2, res[64], res[63:32], res[31:0], busy_n, done_n);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero: got %b want 0", div_zero); else passed++;
    checks++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else passed++;
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_ops;
    logic [1:0]  ops[7] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10};
    logic [31:0] as[7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd100};
    logic [31:0] bs[7]  = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9};
    int bn, dn;
    logic [64:0] res, e;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], as[i], bs[i]);
      run_wait(bn, dn, res);
      e = sb.pop_front();
      checks++; if (res !== e) $display("FAIL op%0d_result: got %h want %h", i, res, e); else passed++;
      checks++; if (bn !== 34) $display("FAIL op%0d_busy_cycles: got %0d want 34", i, bn); else passed++;
      checks++; if (dn !== 1) $display("FAIL op%0d_done_pulses: got %0d want 1", i, dn); else passed++;
    end
  endtask

  task automatic test_div_zero;
    int bn, dn;
    logic [64:0] res, e;
    issue(2'b11, 32'd5, 32'd0);
    run_wait(bn, dn, res);
    e = sb.pop_front();
    checks++; if (res !== e) $display("FAIL divzero_result: got %h want %h", res, e); else passed++;
    checks++; if (div_zero !== 1'b1) $display("FAIL divzero_sticky: got %b want 1", div_zero); else passed++;
    issue(2'b01, 32'd2, 32'd3);
    checks++; if (div_zero !== 1'b0) $display("FAIL divzero_clear: got %b want 0", div_zero); else passed++;
    run_wait(bn, dn, res);
    e = sb.pop_front();
    checks++; if (res !== e) $display("FAIL divzero_next_result: got %h want %h", res, e); else passed++;
  endtask

  task automatic test_conflicts;
    int bn, dn;
    logic [64:0] res, e, prev;
    prev = model(2'b01, 32'd2, 32'd3);
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 2'b11; Read_data_1 = 32'd0; Read_data_2 = 32'd0;
    hi_we = 1'b1; wr_data = 32'h1234;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== prev[63:32]) $display("FAIL busy_hi_we: got %h want %h", hi, prev[63:32]); else passed++;
    run_wait(bn, dn, res);
    e = sb.pop_front();
    checks++; if (res !== e) $display("FAIL busy_start_ignored: got %h want %h", res, e); else passed++;
    checks++; if (dn !== 1) $display("FAIL busy_done_pulses: got %0d want 1", dn); else passed++;
    lo_we = 1'b1; wr_data = 32'hABCD;
    @(negedge clock);
    lo_we = 1'b0;
    checks++; if (lo !== 32'hABCD) $display("FAIL mtlo: got %h want 0000abcd", lo); else passed++;
    checks++; if (hi !== e[63:32]) $display("FAIL mtlo_hi_kept: got %h want %h", hi, e[63:32]); else passed++;
    hi_we = 1'b1; wr_data = 32'h5555;
    issue(2'b01, 32'd2, 32'd3);
    hi_we = 1'b0;
    checks++; if (hi !== e[63:32]) $display("FAIL start_drops_mthi: got %h want %h", hi, e[63:32]); else passed++;
    run_wait(bn, dn, res);
    e = sb.pop_front();
    checks++; if (res !== e) $display("FAIL start_mthi_result: got %h want %h", res, e); else passed++;
  endtask

  task automatic test_back_to_back;
    int bn, dn;
    logic [64:0] res, e;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = (i == 3) ? 32'd0 : ((i % 2) ? $urandom() : 32'($urandom_range(1, 1000)));
      issue(o, a, b);
      run_wait(bn, dn, res);
      e = sb.pop_front();
      checks++; if (res !== e) $display("FAIL b2b%0d_result: got %h want %h", i, res, e); else passed++;
      checks++; if (bn !== 34) $display("FAIL b2b%0d_busy_cycles: got %0d want 34", i, bn); else passed++;
    end
  endtask

  task automatic test_reset_mid;
    int bn, dn;
    logic [64:0] res, e;
    issue(2'b01, 32'hFFFF_FFFF, 32'h1357);
    void'(sb.pop_back());
    repeat (10) @(negedge clock);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
    checks++; if ({hi, lo} !== 64'd0) $display("FAIL midreset_hilo: got %h want 0", {hi, lo}); else passed++;
    checks++; if (done !== 1'b0 || div_zero !== 1'b0) $display("FAIL midreset_flags: got %b%b want 00", done, div_zero); else passed++;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    issue(2'b01, 32'd3, 32'd4);
    run_wait(bn, dn, res);
    e = sb.pop_front();
    checks++; if (res !== e) $display("FAIL midreset_next_result: got %h want %h", res, e); else passed++;
    checks++; if (bn !== 34) $display("FAIL midreset_busy_cycles: got %0d want 34", bn); else passed++;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_div_zero();
    test_conflicts();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
